// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection and EX forwarding-select unit.
// A shift-register scoreboard tracks every issued instruction through EX, MEM and WB.
module hazard_scoreboard #(
    parameter int AW = 5,
    parameter int LOAD_LAT = 1,
    parameter int CW = 16,
    localparam int D = LOAD_LAT + 2,
    localparam int FW = ($clog2(D) > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic [CW-1:0] stall_count
);

    logic [D-1:0]        v_q;
    logic [D-1:0]        wr_q;
    logic [LOAD_LAT:0]   ld_q;
    logic [AW-1:0]       rd_q [D];
    logic [AW-1:0]       rs_q;
    logic [AW-1:0]       rt_q;
    logic [CW-1:0]       cnt_q;
    logic                hazard;
    logic                issue;
    logic                sel_ld;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (v_q[k] && ld_q[k] && wr_q[k] && rd_q[k] != '0) begin
                if ((id_use_rs && rd_q[k] == id_rs) ||
                    (id_use_rt && rd_q[k] == id_rt)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign stall = id_valid && !flush && !reset && hazard;
    assign issue = id_valid && !stall && !flush;
    assign ex_valid = v_q[0];
    assign stall_count = cnt_q;

    // Descending scan so the youngest matching producer is the last to win.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = D - 1; k >= 1; k--) begin
            if (v_q[k] && wr_q[k] && rd_q[k] != '0) begin
                if (rd_q[k] == rs_q) begin
                    fwd_a = FW'(k);
                end
                if (rd_q[k] == rt_q) begin
                    fwd_b = FW'(k);
                end
            end
        end
        if (!v_q[0]) begin
            fwd_a = '0;
            fwd_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < D; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            v_q[0]  <= issue;
            wr_q[0] <= issue & id_regwrite;
            ld_q[0] <= issue & id_memread;
            rd_q[0] <= issue ? id_rd : '0;
            // Unread sources are parked on r0 so they can never pick a forward.
            rs_q    <= (issue && id_use_rs) ? id_rs : '0;
            rt_q    <= (issue && id_use_rt) ? id_rt : '0;

            v_q[1]  <= v_q[0] & ~flush;
            wr_q[1] <= wr_q[0] & ~flush;
            ld_q[1] <= ld_q[0] & ~flush;
            rd_q[1] <= flush ? '0 : rd_q[0];

            for (int k = 2; k < D; k++) begin
                v_q[k]  <= v_q[k-1];
                wr_q[k] <= wr_q[k-1];
                rd_q[k] <= rd_q[k-1];
            end
            for (int k = 2; k <= LOAD_LAT; k++) begin
                ld_q[k] <= ld_q[k-1];
            end

            if (stall && cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // A load still in flight must never be chosen as a forwarding source.
    always_comb begin
        sel_ld = 1'b0;
        for (int k = 1; k <= LOAD_LAT; k++) begin
            if (v_q[0] && ld_q[k] &&
                (fwd_a == FW'(k) || fwd_b == FW'(k))) begin
                sel_ld = 1'b1;
            end
        end
    end

    a_no_load_fwd: assert property (@(posedge clk) disable iff (reset) !sel_ld);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one stimulus
// stream and are checked against an issue-history reference model.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, id_use_rs, id_use_rt;
    logic       id_regwrite, id_memread, flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        st1, st3, st6, ex1, ex3, ex6;
    logic [1:0]  fa1, fb1;
    logic [2:0]  fa3, fb3, fa6, fb6;
    logic [15:0] c1, c3;
    logic [1:0]  c6;

    hazard_scoreboard #(.AW(5), .LOAD_LAT(1), .CW(16)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush),
        .stall(st1), .ex_valid(ex1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_count(c1)
    );

    hazard_scoreboard #(.AW(5), .LOAD_LAT(3), .CW(16)) u3 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush),
        .stall(st3), .ex_valid(ex3),
        .fwd_a(fa3), .fwd_b(fb3), .stall_count(c3)
    );

    hazard_scoreboard #(.AW(5), .LOAD_LAT(6), .CW(2)) u6 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush),
        .stall(st6), .ex_valid(ex6),
        .fwd_a(fa6), .fwd_b(fb6), .stall_count(c6)
    );

    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int rd;
        int rs;
        int rt;
        bit urs;
        bit urt;
    } ins_t;

    localparam int NC = 2048;

    // lg[i][t] is what entered EX at edge t; stage k at cycle t is lg[i][t-k].
    ins_t lg [3][NC];
    int   lat  [3] = '{1, 3, 6};
    int   cmax [3] = '{65535, 65535, 3};
    int   cnt  [3];
    int   cyc;
    int   total;
    int   bad;
    int   expc [5] = '{1, 2, 3, 3, 3};

    function automatic ins_t blank();
        ins_t z;
        z.v = 1'b0; z.wr = 1'b0; z.ld = 1'b0;
        z.rd = 0; z.rs = 0; z.rt = 0;
        z.urs = 1'b0; z.urt = 1'b0;
        return z;
    endfunction

    function automatic ins_t ent(int i, int k);
        if (cyc - k < 0) return blank();
        return lg[i][cyc - k];
    endfunction

    function automatic bit m_stall(int i);
        ins_t e;
        if (!id_valid || flush || reset) return 1'b0;
        for (int k = 0; k < lat[i]; k++) begin
            e = ent(i, k);
            if (e.v && e.ld && e.wr && e.rd != 0 &&
                ((id_use_rs && e.rd == int'(id_rs)) ||
                 (id_use_rt && e.rd == int'(id_rt))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_fwd(int i, bit a);
        ins_t e, p;
        int r;
        e = ent(i, 0);
        if (!e.v) return 0;
        r = a ? (e.urs ? e.rs : 0) : (e.urt ? e.rt : 0);
        if (r == 0) return 0;
        for (int k = 1; k <= lat[i] + 1; k++) begin
            p = ent(i, k);
            if (p.v && p.wr && p.rd == r) return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        ins_t cur;
        bit   s;
        @(negedge clk);
        chk("u1.stall", st1, m_stall(0));
        chk("u1.exv", ex1, ent(0, 0).v);
        chk("u1.fwd_a", fa1, m_fwd(0, 1'b1));
        chk("u1.fwd_b", fb1, m_fwd(0, 1'b0));
        chk("u1.cnt", c1, cnt[0]);
        chk("u3.stall", st3, m_stall(1));
        chk("u3.exv", ex3, ent(1, 0).v);
        chk("u3.fwd_a", fa3, m_fwd(1, 1'b1));
        chk("u3.fwd_b", fb3, m_fwd(1, 1'b0));
        chk("u3.cnt", c3, cnt[1]);
        chk("u6.stall", st6, m_stall(2));
        chk("u6.exv", ex6, ent(2, 0).v);
        chk("u6.fwd_a", fa6, m_fwd(2, 1'b1));
        chk("u6.fwd_b", fb6, m_fwd(2, 1'b0));
        chk("u6.cnt", c6, cnt[2]);
        cur.v = 1'b1; cur.wr = id_regwrite; cur.ld = id_memread;
        cur.rd = int'(id_rd); cur.rs = int'(id_rs); cur.rt = int'(id_rt);
        cur.urs = id_use_rs; cur.urt = id_use_rt;
        for (int i = 0; i < 3; i++) begin
            s = m_stall(i);
            if (reset) begin
                for (int j = 0; j <= 8; j++)
                    if (cyc - j >= 0) lg[i][cyc - j].v = 1'b0;
                cnt[i] = 0;
                lg[i][cyc + 1] = blank();
            end else begin
                if (s && cnt[i] < cmax[i]) cnt[i]++;
                if (flush) lg[i][cyc].v = 1'b0;
                lg[i][cyc + 1] = (id_valid && !s && !flush) ? cur : blank();
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs = '0; id_rt = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
    endtask

    task automatic setid(input bit v, input int rs, input int rt,
                         input bit urs, input bit urt, input int rd,
                         input bit rw, input bit mr);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_rd = 5'(rd);
        id_regwrite = rw; id_memread = mr;
    endtask

    task automatic rst_pulse();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        step();
        #1;
        chk("rst.stall", st1, 0);
        chk("rst.exv", ex1, 0);
        chk("rst.cnt", c3, 0);
        reset = 1'b0;

        // LOAD_LAT=1: lw $5 ; add $6,$5,$5
        rst_pulse();
        setid(1, 2, 0, 1, 0, 5, 1, 1);
        #1 chk("t1.lw", st1, 0);
        step();
        setid(1, 5, 5, 1, 1, 6, 1, 0);
        #1 chk("t1.stall", st1, 1);
        step();
        #1 chk("t1.release", st1, 0);
        chk("t1.bubble", ex1, 0);
        step();
        idle();
        #1 chk("t1.exv", ex1, 1);
        chk("t1.fa", fa1, 2);
        chk("t1.fb", fb1, 2);
        chk("t1.cnt", c1, 1);
        step();

        // LOAD_LAT=3: lw $7 ; nop ; or $8,$7,$0
        rst_pulse();
        setid(1, 0, 0, 0, 0, 7, 1, 1);
        step();
        setid(1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t2.nop", st3, 0);
        step();
        setid(1, 7, 0, 1, 0, 8, 1, 0);
        #1 chk("t2.stall1", st3, 1);
        step();
        #1 chk("t2.stall2", st3, 1);
        step();
        #1 chk("t2.release", st3, 0);
        step();
        idle();
        #1 chk("t2.exv", ex3, 1);
        chk("t2.fa", fa3, 4);
        chk("t2.fb", fb3, 0);
        chk("t2.cnt", c3, 2);
        step();

        // ALU chain: add $3 ; sub $3 ; and $9,$3,$3
        rst_pulse();
        setid(1, 1, 2, 1, 1, 3, 1, 0);
        #1 chk("t3.add", st1, 0);
        step();
        setid(1, 4, 5, 1, 1, 3, 1, 0);
        step();
        setid(1, 3, 3, 1, 1, 9, 1, 0);
        #1 chk("t3.and.u1", st1, 0);
        chk("t3.and.u3", st3, 0);
        step();
        idle();
        #1 chk("t3.fa1", fa1, 1);
        chk("t3.fb1", fb1, 1);
        chk("t3.fa3", fa3, 1);
        step();

        // r0 and unused source operands
        rst_pulse();
        setid(1, 0, 0, 0, 0, 0, 1, 1);
        step();
        setid(1, 0, 0, 1, 1, 10, 1, 0);
        #1 chk("t4.r0.u1", st1, 0);
        chk("t4.r0.u3", st3, 0);
        step();
        idle();
        #1 chk("t4.r0.fa", fa1, 0);
        chk("t4.r0.fb", fb1, 0);
        step();
        setid(1, 0, 0, 0, 0, 4, 1, 1);
        step();
        setid(1, 4, 4, 0, 0, 11, 1, 0);
        #1 chk("t4.nouse.u1", st1, 0);
        chk("t4.nouse.u3", st3, 0);
        step();
        idle();
        #1 chk("t4.nouse.fa1", fa1, 0);
        chk("t4.nouse.fb1", fb1, 0);
        chk("t4.nouse.fa3", fa3, 0);
        step();

        // flush with a load in MEM and a dependent in ID (LOAD_LAT=3)
        rst_pulse();
        setid(1, 0, 0, 0, 0, 5, 1, 1);
        step();
        setid(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        setid(1, 5, 5, 1, 1, 6, 1, 0);
        flush = 1'b1;
        #1 chk("t5.flush", st3, 0);
        step();
        flush = 1'b0;
        #1 chk("t5.exv", ex3, 0);
        chk("t5.cnt", c3, 0);
        chk("t5.ldalive", st3, 1);
        step();
        #1 chk("t5.release", st3, 0);
        step();
        idle();
        #1 chk("t5.fa", fa3, 4);
        chk("t5.fb", fb3, 4);
        chk("t5.cnt2", c3, 1);
        step();

        // CW=2 saturation, then reset mid-stall (LOAD_LAT=6)
        rst_pulse();
        setid(1, 0, 0, 0, 0, 5, 1, 1);
        #1 chk("t6.lw", st6, 0);
        step();
        setid(1, 5, 0, 1, 0, 6, 1, 0);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t6.stall", st6, 1);
            step();
            chk("t6.cnt", c6, expc[i]);
        end
        reset = 1'b1;
        #1 chk("t6.rst.stall", st6, 0);
        step();
        reset = 1'b0;
        #1 chk("t6.post.cnt", c6, 0);
        chk("t6.post.exv", ex6, 0);
        chk("t6.post.stall", st6, 0);
        step();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            setid($urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        for (int n = 0; n < 10; n++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use hazard detection and forwarding-select unit for the pipelined MIPS core. It tracks every instruction issued out of ID through a shift-register scoreboard covering EX, a configurable-length memory stage, and WB. The ID stage is stalled only when a load result cannot yet be forwarded. EX operand forwarding selects are generated from the same scoreboard. Support for multi-cycle data memories, flush on taken branch/jump, and a stall-cycle counter are added over the single-cycle-load hazard check.

## Interface
- AW, 5: register-address width.
- LOAD_LAT, 1: number of memory stages; load data is valid at the end of the last one (≥1).
- CW, 16: stall counter width.
- Derived: D = LOAD_LAT+2 scoreboard stages (0 = EX, 1..LOAD_LAT = MEM, D-1 = WB); FW = max(1, clog2(D)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  ID source register numbers.
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt.
- id_rd  in  AW  resolved destination (after RegDst).
- id_regwrite  in  1  ID instruction writes a register.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  kill the ID and EX instructions this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- ex_valid  out  1  EX holds a real instruction.
- fwd_a, fwd_b  out  FW  EX operand source: 0 = register file, k = scoreboard stage k.
- stall_count  out  CW  saturating count of stall cycles.

## Operation
- Scoreboard entry per stage: {v, wr, ld, rd[AW], rs[AW], rt[AW]}. Only stage 0 needs rs/rt.
- Every cycle, entries shift stage k → k+1 and the stage D-1 entry retires. The back end never stalls.
- Stage 0 load:
  - ID instruction if id_valid && !stall && !flush.
  - Otherwise a bubble: v=0, other fields 0.
- flush: the stage 0 entry shifting into stage 1 becomes a bubble, and stage 0 receives a bubble. MEM/WB are unaffected.
- Hazard term (combinational): for stage k in 0..LOAD_LAT-1, stage k has v && ld && wr && rd≠0, and either (id_use_rs && rd==id_rs) or (id_use_rt && rd==id_rt).
- stall = id_valid && !flush && !reset && OR of the hazard term over those stages.
- With LOAD_LAT=1 this is the classic single check: load in EX, dependent instruction in ID.
- fwd_a: smallest k in 1..D-1 with stage k v && wr && rd≠0 && rd==stage0.rs. If none match, or stage 0 is not valid, fwd_a = 0. The youngest producer wins.
- fwd_b: same rule using stage0.rt.
- A load is never selected while in stages 1..LOAD_LAT; the stall rule guarantees this. Verification asserts it.
- Register 0 never causes a stall or a forward.
- stall_count: increments by 1 each cycle stall=1 and saturates at 2^CW-1.

## Timing
- stall, fwd_a, fwd_b, ex_valid are combinational from registered state and ID inputs, valid in the same cycle. stall has no registered latency.
- A dependent instruction following a load is stalled exactly LOAD_LAT-d cycles, where d is the number of independent instructions between them (minimum 0).
- An ALU producer is never stalled on. Its result is forwarded from stage 1 on the consumer's first EX cycle.
- Reset values: all entries v=0 with fields 0; stall=0 (forced low while reset is high); ex_valid=0; fwd_a=fwd_b=0; stall_count=0.
- Reset mid-operation: the scoreboard is cleared on that edge, and no stall occurs in the cycle after reset deasserts.
- Simultaneous flush and hazard: flush wins; stall=0, the counter does not increment, and the load still advances.
- id_valid=0 never stalls, even if its fields match.

## Test plan
- LOAD_LAT=1: `lw $5` then `add $6,$5,$5` → stall=1 for 1 cycle; next cycle stage 0 is a bubble; add in EX gives fwd_a=fwd_b=2; stall_count=1.
- LOAD_LAT=3: `lw $7`, `nop`, `or $8,$7,$0` (use_rs) → stall for 2 cycles; or enters EX with fwd_a=4 (WB); stall_count=2.
- ALU chain `add $3`, `sub $3`, `and $9,$3,$3` → no stall; and in EX gives fwd_a=fwd_b=1 (youngest sub, not add at stage 2).
- `lw $0` then use of `$0`, and `lw $4` followed by an instruction with id_use_rs=id_use_rt=0 but rs=4 → stall=0 and fwd=0 throughout.
- `lw $5`, dependent in ID with flush=1 in the same cycle → stall=0; next cycle ex_valid=0; the load continues to WB; the counter is unchanged.
- CW=2: force 5 consecutive stall cycles → stall_count reads 1,2,3,3,3. Assert reset mid-sequence → count=0, ex_valid=0, stall=0 next cycle.
